id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Decode-side receiver for the fetch-to-decode handshake; it is the consumer end of the 64-bit {pc, inst} bus.
- Accepts fetch packets through a valid/ready handshake into a 2-entry skid buffer.
- Extracts RV32I fields, format and immediate from the head entry.
- Presents the result to EXE through a second valid/ready handshake; a flush input drops all buffered packets on redirect.

Parameters:
- PC_W, 32, PC width; upper field of in_bus.
- INST_W, 32, instruction width; lower field of in_bus.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  fetch packet valid
- in_ready  out  1  decode can accept (not full)
- in_bus  in  PC_W+INST_W  {pc[63:32], inst[31:0]}
- flush  in  1  discard all buffered packets
- out_valid  out  1  decoded packet valid to EXE
- out_ready  in  1  EXE accepts
- out_pc  out  PC_W  pc of head packet
- out_inst  out  INST_W  raw instruction
- out_opcode  out  7  inst[6:0]
- out_rd  out  5  inst[11:7]
- out_rs1  out  5  inst[19:15]
- out_rs2  out  5  inst[24:20]
- out_funct3  out  3  inst[14:12]
- out_funct7  out  7  inst[31:25]
- out_fmt  out  3  format code R/I/S/B/U/J/NONE
- out_imm  out  32  sign-extended immediate
- out_illegal  out  1  unrecognised encoding

Behaviour:
- Storage: 2 entries of {pc, inst}, head/tail pointers of 1 bit each, count 0..2.
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- in_ready = (count != 2). It is derived only from registered state, so there is no combinational path from out_ready to in_ready.
- out_valid = (count != 0). All out_* fields are taken from the head entry. Decode is combinational from the stored inst.
- Latency: a packet accepted at edge N is visible on out_* in cycle N+1. Throughput is 1 packet per cycle when out_ready is held at 1.
- Ordering is strict FIFO; head and tail pointers wrap 1 -> 0.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together at count 1: count stays 1, head and tail both advance
  - push at count 2 cannot occur because in_ready=0
- While out_valid=1 and out_ready=0, all out_* fields hold stable.
- flush (priority over everything): at the edge, count <- 0 and head = tail <- 0. A simultaneous in_fire is dropped and a simultaneous out_fire is ignored. out_valid=0 from the next cycle, and in_ready=1 from the next cycle.
- Reset: count, head and tail <- 0; entry registers <- 0. From the first cycle after reset, out_valid=0, in_ready=1, and out_* fields read as decode of 0x00000000 (out_illegal=1, but gated by out_valid=0). Reset mid-transfer drops all entries exactly like flush.
- Format by opcode:
  - 0110011 -> R, imm 0
  - 0010011, 0000011, 1100111, 1110011 -> I, imm = sext(inst[31:20])
  - 0100011 -> S, imm = sext({inst[31:25], inst[11:7]})
  - 1100011 -> B, imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0})
  - 0110111, 0010111 -> U, imm = {inst[31:12], 12'h0}
  - 1101111 -> J, imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0})
  - any other opcode, or inst[1:0] != 2'b11 -> fmt NONE, imm 0, out_illegal=1
- Raw field outputs (rd/rs1/rs2/funct3/funct7) are driven from their fixed bit positions regardless of format.

Decomposition:
- Shared package (defines.sv / core package): opcode constants (OP, OP_IMM, LOAD, JALR, SYSTEM, STORE, BRANCH, LUI, AUIPC, JAL); 3-bit fmt enum (R=0, I=1, S=2, B=3, U=4, J=5, NONE=7); PC_W/INST_W defaults; bus field offsets for {pc, inst}.
- One sub-module: id_imm_gen, combinational. Input inst; outputs fmt, imm, illegal. Instanced once on the head entry.

Test Plan:
- Basic decode: push pc=0x4, inst=0x00500093 with out_ready=1 -> next cycle out_valid=1, pc 0x4, opcode 0x13, rd 1, rs1 0, fmt I, imm 0x00000005, illegal 0.
- Immediate forms: push 0xFE208EE3 -> fmt B, rs1 1, rs2 2, imm 0xFFFFFFFC. Push 0x123452B7 -> fmt U, rd 5, imm 0x12345000. Push 0x008000EF -> fmt J, rd 1, imm 0x00000008.
- Backpressure: hold out_ready=0 and push pc 0x0 then 0x4 -> in_ready=0 after the second push, and out_pc holds 0x0 stable. Raise out_ready -> out_pc 0x0 then 0x4 on consecutive cycles. in_ready returns to 1 one cycle after the first pop.
- Streaming: in_valid=1 and out_ready=1 continuously for 8 packets, pc 0x0..0x1C -> one output per cycle in order, count never exceeds 1, in_ready stays 1.
- Flush: with 2 entries buffered, assert flush in the same cycle as in_valid=1 -> next cycle out_valid=0, in_ready=1, and neither the buffered packets nor the flushed input ever appear on out_*.
- Illegal and reset: push 0x00000000 -> out_valid=1, fmt NONE, illegal=1, imm 0. Assert reset while 1 entry is buffered -> next cycle out_valid=0, in_ready=1.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared definitions for the decode stage: RV32I opcodes, format codes and
// the layout of the {pc, inst} fetch bus.
package id_stage_pkg;

  localparam int PC_W_DEF   = 32;
  localparam int INST_W_DEF = 32;

  // Field offsets inside the {pc, inst} bus (inst occupies the low bits)
  localparam int BUS_INST_LSB = 0;
  localparam int BUS_PC_LSB   = INST_W_DEF;

  // RV32I major opcodes
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

endpackage

// File: rtl/id_imm_gen.sv
// Combinational RV32I format classifier and immediate generator.
module id_imm_gen
  import id_stage_pkg::*;
(
  input  logic [31:0] inst,
  output logic [2:0]  fmt,
  output logic [31:0] imm,
  output logic        illegal
);

  fmt_e fmt_sel;

  // Classify the opcode and assemble the sign-extended immediate for it
  always_comb begin
    fmt_sel = FMT_NONE;
    imm     = 32'h0;
    illegal = 1'b0;
    case (inst[6:0])
      OP: begin
        fmt_sel = FMT_R;
      end
      OP_IMM, LOAD, JALR, SYSTEM: begin
        fmt_sel = FMT_I;
        imm     = {{20{inst[31]}}, inst[31:20]};
      end
      STORE: begin
        fmt_sel = FMT_S;
        imm     = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      BRANCH: begin
        fmt_sel = FMT_B;
        imm     = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      LUI, AUIPC: begin
        fmt_sel = FMT_U;
        imm     = {inst[31:12], 12'h0};
      end
      JAL: begin
        fmt_sel = FMT_J;
        imm     = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
    // Compressed-space encodings are not RV32I; every valid opcode ends in 11
    if (inst[1:0] != 2'b11) begin
      fmt_sel = FMT_NONE;
      imm     = 32'h0;
      illegal = 1'b1;
    end
  end

  assign fmt = fmt_sel;

endmodule

// File: rtl/id_stage.sv
// Decode stage: 2-entry skid buffer on the fetch handshake, head entry
// decoded combinationally and offered to EXE on a second handshake.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int INST_W = INST_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PC_W+INST_W-1:0] in_bus,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        out_pc,
  output logic [INST_W-1:0]      out_inst,
  output logic [6:0]             out_opcode,
  output logic [4:0]             out_rd,
  output logic [4:0]             out_rs1,
  output logic [4:0]             out_rs2,
  output logic [2:0]             out_funct3,
  output logic [6:0]             out_funct7,
  output logic [2:0]             out_fmt,
  output logic [31:0]            out_imm,
  output logic                   out_illegal
);

  localparam int BUS_W = PC_W + INST_W;

  logic [BUS_W-1:0] mem_q [2];
  logic [BUS_W-1:0] mem_d [2];
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             in_fire, out_fire;
  logic [BUS_W-1:0] head_entry;

  // Handshake status comes only from registered occupancy
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Next-state for pointers, occupancy and entry storage; flush wins over both fires
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    for (int i = 0; i < 2; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (flush) begin
      head_d  = 1'b0;
      tail_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      if (in_fire) begin
        mem_d[tail_q] = in_bus;
        tail_d        = ~tail_q;
      end
      if (out_fire) begin
        head_d = ~head_q;
      end
      if (in_fire && !out_fire) begin
        count_d = count_q + 2'd1;
      end else if (!in_fire && out_fire) begin
        count_d = count_q - 2'd1;
      end
    end
  end

  // State registers; reset clears the entries so an empty stage decodes 0x0
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign head_entry = mem_q[head_q];
  assign out_pc     = head_entry[BUS_W-1:INST_W];
  assign out_inst   = head_entry[INST_W-1:0];
  assign out_opcode = out_inst[6:0];
  assign out_rd     = out_inst[11:7];
  assign out_funct3 = out_inst[14:12];
  assign out_rs1    = out_inst[19:15];
  assign out_rs2    = out_inst[24:20];
  assign out_funct7 = out_inst[31:25];

  id_imm_gen u_imm_gen (
    .inst    (out_inst[31:0]),
    .fmt     (out_fmt),
    .imm     (out_imm),
    .illegal (out_illegal)
  );

endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_bus;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [2:0]  out_fmt;
  logic [31:0] out_imm;
  logic        out_illegal;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_bus      (in_bus),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .out_opcode  (out_opcode),
    .out_rd      (out_rd),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_funct3  (out_funct3),
    .out_funct7  (out_funct7),
    .out_fmt     (out_fmt),
    .out_imm     (out_imm),
    .out_illegal (out_illegal)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst);
    in_valid = 1'b1;
    in_bus   = {pc, inst};
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_bus    = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_fmt", out_fmt, 7);
    chk("rst_illegal", out_illegal, 1);
    chk("rst_imm", out_imm, 0);

    // Basic decode: addi x1, x0, 5
    out_ready = 1'b1;
    push(32'h4, 32'h00500093);
    chk("addi_valid", out_valid, 1);
    chk("addi_pc", out_pc, 32'h4);
    chk("addi_opcode", out_opcode, 7'h13);
    chk("addi_rd", out_rd, 1);
    chk("addi_rs1", out_rs1, 0);
    chk("addi_fmt", out_fmt, 1);
    chk("addi_imm", out_imm, 32'h5);
    chk("addi_illegal", out_illegal, 0);
    step();
    chk("addi_drained", out_valid, 0);

    // B-type
    push(32'h8, 32'hFE208EE3);
    chk("beq_fmt", out_fmt, 3);
    chk("beq_rs1", out_rs1, 1);
    chk("beq_rs2", out_rs2, 2);
    chk("beq_imm", out_imm, 32'hFFFFFFFC);
    step();
    // U-type
    push(32'hC, 32'h123452B7);
    chk("lui_fmt", out_fmt, 4);
    chk("lui_rd", out_rd, 5);
    chk("lui_imm", out_imm, 32'h12345000);
    step();
    // J-type
    push(32'h10, 32'h008000EF);
    chk("jal_fmt", out_fmt, 5);
    chk("jal_rd", out_rd, 1);
    chk("jal_imm", out_imm, 32'h8);
    step();
    // Illegal encoding
    push(32'h14, 32'h00000000);
    chk("ill_valid", out_valid, 1);
    chk("ill_fmt", out_fmt, 7);
    chk("ill_flag", out_illegal, 1);
    chk("ill_imm", out_imm, 0);
    step();

    // Backpressure: fill both entries, then drain in order
    out_ready = 1'b0;
    push(32'h0, 32'h00100093);
    chk("bp_in_ready_1", in_ready, 1);
    push(32'h4, 32'h00200093);
    chk("bp_in_ready_full", in_ready, 0);
    chk("bp_pc_hold0", out_pc, 32'h0);
    step();
    chk("bp_pc_hold1", out_pc, 32'h0);
    chk("bp_imm_hold", out_imm, 32'h1);
    out_ready = 1'b1;
    step();
    chk("bp_pc_second", out_pc, 32'h4);
    chk("bp_imm_second", out_imm, 32'h2);
    chk("bp_in_ready_back", in_ready, 1);
    step();
    chk("bp_empty", out_valid, 0);

    // Streaming: push and pop every cycle
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_bus   = {32'(i * 4), 32'h00000013 | (32'(i) << 20)};
      step();
      chk($sformatf("str%0d_valid", i), out_valid, 1);
      chk($sformatf("str%0d_pc", i), out_pc, 64'(i * 4));
      chk($sformatf("str%0d_imm", i), out_imm, 64'(i));
      chk($sformatf("str%0d_in_ready", i), in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    chk("str_drained", out_valid, 0);

    // Flush with two entries buffered and a simultaneous push
    out_ready = 1'b0;
    push(32'h100, 32'h00100093);
    push(32'h104, 32'h00200093);
    chk("fl_full", in_ready, 0);
    out_ready = 1'b1;
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_bus    = {32'h108, 32'h00300093};
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    step();
    chk("fl_still_empty", out_valid, 0);
    push(32'h200, 32'h00400093);
    chk("fl_next_pc", out_pc, 32'h200);
    chk("fl_next_imm", out_imm, 32'h4);
    step();
    chk("fl_next_drained", out_valid, 0);

    // Reset while one entry is buffered
    out_ready = 1'b0;
    push(32'h300, 32'h00500093);
    chk("rs_buffered", out_valid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rs_out_valid", out_valid, 0);
    chk("rs_in_ready", in_ready, 1);
    chk("rs_pc_cleared", out_pc, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
